// File: rtl/hamming_8bit_codec.sv
// Hamming(12,8) single-error-correcting codec.
// The encoder is purely combinational; the decoder registers its corrected
// byte and status flags on sys_clk with one cycle of latency.
// Optional build macro: HAMMING_SYNDROME_OUT_EN exposes the registered raw
// syndrome on syndrome_out; without it the syndrome stays internal.
module hamming_8bit_codec (
  input  logic        sys_clk,
  input  logic        rstn,
  input  logic [7:0]  enc_data_in,
  output logic [11:0] enc_code_out,
  input  logic [11:0] dec_code_in,
  output logic [7:0]  dec_data_out,
  output logic        error_flag,
  output logic        correct_flag
`ifdef HAMMING_SYNDROME_OUT_EN
  ,
  output logic [3:0]  syndrome_out
`endif
);

  // Even parity over the data bits; result packed as {p3, p2, p1, p0}.
  function automatic logic [3:0] calcParity(input logic [7:0] d);
    logic [3:0] p;
    p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return p;
  endfunction

  logic [7:0] w_rxData;
  logic [3:0] w_syndrome;
  logic [7:0] w_fixedData;
  logic       w_error;
  logic       w_correct;

  logic [7:0] r_decData;
  logic       r_error;
  logic       r_correct;
  logic [3:0] r_syndrome;

  // Encoder: data in the upper byte, parity in the low nibble.
  always_comb begin
    enc_code_out = {enc_data_in, calcParity(enc_data_in)};
  end

  // Syndrome is the Hamming position of a single flipped bit, 0 when clean.
  always_comb begin
    w_rxData   = dec_code_in[11:4];
    w_syndrome = calcParity(w_rxData) ^ dec_code_in[3:0];
  end

  // Map the syndrome onto a data-bit correction and the status flags;
  // parity-only errors leave the data untouched but still count as corrected,
  // and positions 13..15 do not exist so they signal a multi-bit error.
  always_comb begin
    w_fixedData = w_rxData;
    w_error     = 1'b1;
    w_correct   = 1'b1;
    case (w_syndrome)
      4'd0:  begin
        w_error   = 1'b0;
        w_correct = 1'b0;
      end
      4'd3:  w_fixedData[0] = ~w_rxData[0];
      4'd5:  w_fixedData[1] = ~w_rxData[1];
      4'd6:  w_fixedData[2] = ~w_rxData[2];
      4'd7:  w_fixedData[3] = ~w_rxData[3];
      4'd9:  w_fixedData[4] = ~w_rxData[4];
      4'd10: w_fixedData[5] = ~w_rxData[5];
      4'd11: w_fixedData[6] = ~w_rxData[6];
      4'd12: w_fixedData[7] = ~w_rxData[7];
      4'd1, 4'd2, 4'd4, 4'd8: w_fixedData = w_rxData;
      default: w_correct = 1'b0;
    endcase
  end

  // Decoder output register; reset clears any in-flight result immediately.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_decData  <= 8'h00;
      r_error    <= 1'b0;
      r_correct  <= 1'b0;
      r_syndrome <= 4'h0;
    end else begin
      r_decData  <= w_fixedData;
      r_error    <= w_error;
      r_correct  <= w_correct;
      r_syndrome <= w_syndrome;
    end
  end

  assign dec_data_out = r_decData;
  assign error_flag   = r_error;
  assign correct_flag = r_correct;

`ifdef HAMMING_SYNDROME_OUT_EN
  assign syndrome_out = r_syndrome;
`else
  logic w_unusedSyndrome;
  assign w_unusedSyndrome = ^r_syndrome;
`endif

endmodule

// File: tb/tb_hamming_8bit_codec.sv
// Directed self-checking bench for hamming_8bit_codec.
// Expected values are hand-computed Hamming(12,8) codewords and decodes.
module tb_hamming_8bit_codec;

  logic        sys_clk;
  logic        rstn;
  logic [7:0]  enc_data_in;
  logic [11:0] enc_code_out;
  logic [11:0] dec_code_in;
  logic [7:0]  dec_data_out;
  logic        error_flag;
  logic        correct_flag;
`ifdef HAMMING_SYNDROME_OUT_EN
  logic [3:0]  syndrome_out;
`endif

  int total = 0;
  int bad   = 0;

  hamming_8bit_codec dut (
    .sys_clk      (sys_clk),
    .rstn         (rstn),
    .enc_data_in  (enc_data_in),
    .enc_code_out (enc_code_out),
    .dec_code_in  (dec_code_in),
    .dec_data_out (dec_data_out),
    .error_flag   (error_flag),
    .correct_flag (correct_flag)
`ifdef HAMMING_SYNDROME_OUT_EN
    ,
    .syndrome_out (syndrome_out)
`endif
  );

  // Free-running 100 MHz decoder clock.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] code;
  } encVec_t;

  typedef struct {
    logic [11:0] code;
    logic [7:0]  data;
    logic        err;
    logic        corr;
    logic [3:0]  syn;
  } decVec_t;

  encVec_t encVecs[8] = '{
    '{8'h00, 12'h000}, '{8'h0A, 12'h0A2}, '{8'hFF, 12'hFF3},
    '{8'hA0, 12'hA06}, '{8'h1B, 12'h1B8}, '{8'h01, 12'h013},
    '{8'h80, 12'h80C}, '{8'h10, 12'h109}
  };

  decVec_t decVecs[11] = '{
    '{12'h1B8, 8'h1B, 1'b0, 1'b0, 4'd0},
    '{12'h022, 8'h0A, 1'b1, 1'b1, 4'd7},
    '{12'h7F3, 8'hFF, 1'b1, 1'b1, 4'd12},
    '{12'hA07, 8'hA0, 1'b1, 1'b1, 4'd1},
    '{12'h801, 8'h80, 1'b1, 1'b0, 4'd13},
    '{12'h009, 8'h10, 1'b1, 1'b1, 4'd9},
    '{12'h0AA, 8'h0A, 1'b1, 1'b1, 4'd8},
    '{12'hFF3, 8'hFF, 1'b0, 1'b0, 4'd0},
    '{12'h00E, 8'h00, 1'b1, 1'b0, 4'd14},
    '{12'h00F, 8'h00, 1'b1, 1'b0, 4'd15},
    '{12'h013, 8'h01, 1'b0, 1'b0, 4'd0}
  };

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [11:0] got,
                             input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Compare all decoder outputs against one expected vector.
  task automatic checkDecoder(input string tag, input decVec_t v);
    checkOutput({tag, " data"}, {4'h0, dec_data_out}, {4'h0, v.data});
    checkOutput({tag, " err"},  {11'h0, error_flag},  {11'h0, v.err});
    checkOutput({tag, " corr"}, {11'h0, correct_flag}, {11'h0, v.corr});
`ifdef HAMMING_SYNDROME_OUT_EN
    checkOutput({tag, " syn"},  {8'h0, syndrome_out}, {8'h0, v.syn});
`endif
  endtask

  // Present one codeword on the falling edge and wait for it to be captured.
  task automatic applyStimulus(input logic [11:0] code);
    @(negedge sys_clk);
    dec_code_in = code;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    decVec_t zeroVec;
    zeroVec     = '{12'h000, 8'h00, 1'b0, 1'b0, 4'd0};
    rstn        = 1'b0;
    enc_data_in = 8'h00;
    dec_code_in = 12'h022;

    // Outputs must be cleared by reset alone, before any clock edge.
    #2;
    checkDecoder("reset-initial", zeroVec);
    repeat (2) @(posedge sys_clk);
    #1;
    checkDecoder("reset-held", zeroVec);

    // Encoder is combinational and independent of reset.
    foreach (encVecs[i]) begin
      enc_data_in = encVecs[i].data;
      #1;
      checkOutput($sformatf("enc 0x%0h", encVecs[i].data),
                  enc_code_out, encVecs[i].code);
    end

    @(negedge sys_clk);
    rstn = 1'b1;

    // Back-to-back decodes, one new codeword every cycle.
    foreach (decVecs[i]) begin
      applyStimulus(decVecs[i].code);
      checkDecoder($sformatf("dec 0x%0h", decVecs[i].code), decVecs[i]);
    end

    // Mid-stream reset with a corrupted codeword applied.
    applyStimulus(12'h022);
    checkDecoder("pre-reset", decVecs[1]);
    #2;
    rstn = 1'b0;
    #1;
    checkDecoder("async-reset", zeroVec);
    @(posedge sys_clk);
    #1;
    checkDecoder("reset-edge", zeroVec);
    @(negedge sys_clk);
    rstn = 1'b1;
    @(posedge sys_clk);
    #1;
    checkDecoder("post-reset", decVecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on simulation length in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
